// File: rtl/uart_packet_framer.sv
// uart_packet_framer: gathers FIFO bytes into a buffer and sends them as SOF/LEN/payload/CRC8 frames
// over the out_start/out_finish UART byte handshake.
module uart_packet_framer #(
    parameter int         MAX_PAYLOAD = 16,
    parameter int         TIMEOUT     = 1024,
    parameter logic [7:0] SOF_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       fifo_re,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    input  logic       fifo_busy,
    output logic       out_start,
    output logic [7:0] out_data,
    input  logic       out_finish,
    output logic       frame_busy,
    output logic [7:0] frame_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND_SOF, SEND_LEN, SEND_PAY, SEND_CRC, WAIT_TX} state_t;
    typedef enum logic [1:0] {K_SOF, K_LEN, K_PAY, K_CRC} kind_t;

    state_t        state, next;
    kind_t         kind;
    logic [7:0]    mem [MAX_PAYLOAD];
    logic [7:0]    cnt, idx, crc, tx_byte;
    logic [TW-1:0] tmo;
    logic          can_fetch, idle_wait, expired, done;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++)
            x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
        return x;
    endfunction

    assign can_fetch = enable && !fifo_empty && !fifo_busy;
    assign idle_wait = cnt != 8'd0 && (fifo_empty || !enable);
    assign expired   = idle_wait && tmo == TW'(TIMEOUT - 1);
    assign done      = state == WAIT_TX && kind == K_CRC && out_finish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            kind        <= K_SOF;
            cnt         <= '0;
            idx         <= '0;
            crc         <= '0;
            tmo         <= '0;
            out_data    <= '0;
            frame_count <= '0;
        end else begin
            state <= next;
            tmo   <= state != IDLE ? '0 : idle_wait ? tmo + 1'b1 : tmo;
            if (state == CAPTURE)
                cnt <= cnt + 8'd1;
            if (state == SEND_SOF)
                idx <= '0;
            if (state == SEND_PAY)
                idx <= idx + 8'd1;
            // CRC covers LEN and payload, folded in as each byte is launched
            if (state == SEND_LEN || state == SEND_PAY)
                crc <= crc8(crc, out_data);
            if (out_start)
                kind <= state == SEND_SOF ? K_SOF : state == SEND_LEN ? K_LEN : state == SEND_PAY ? K_PAY : K_CRC;
            if (next inside {SEND_SOF, SEND_LEN, SEND_PAY, SEND_CRC})
                out_data <= tx_byte;
            if (done) begin
                frame_count <= frame_count + 8'd1;
                cnt         <= '0;
                crc         <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE)
            mem[cnt[AW-1:0]] <= fifo_data;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = expired ? SEND_SOF : can_fetch ? FETCH : IDLE;
            FETCH:    next = (fifo_empty || fifo_busy) ? IDLE : CAPTURE;
            CAPTURE:  next = cnt == 8'(MAX_PAYLOAD - 1) ? SEND_SOF : IDLE;
            SEND_SOF, SEND_LEN, SEND_PAY, SEND_CRC: next = WAIT_TX;
            WAIT_TX:
                if (out_finish)
                    next = kind == K_SOF ? SEND_LEN : kind == K_LEN ? SEND_PAY :
                           kind == K_PAY ? (idx == cnt ? SEND_CRC : SEND_PAY) : IDLE;
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        fifo_re    = state == FETCH && !fifo_empty && !fifo_busy;
        out_start  = state inside {SEND_SOF, SEND_LEN, SEND_PAY, SEND_CRC};
        frame_busy = out_start || state == WAIT_TX;
        tx_byte    = next == SEND_SOF ? SOF_BYTE : next == SEND_LEN ? cnt :
                     next == SEND_PAY ? mem[idx[AW-1:0]] : crc;
    end
endmodule
